data_mem: RTL and testbench

Word-organised data memory for the RV32I core, sitting behind the load/store unit in the memory stage. It provides a combinational (asynchronous) 32-bit read port and a synchronous write port with per-byte write enables. Contents are cleared by an asynchronous active-high reset. A companion interface, `data_mem_intf`, bundles the port signals for benches and coverage collectors.

---
 rtl/data_mem_if.sv | 19 +
 rtl/data_mem.sv | 39 +++
 tb/tb_data_mem.sv | 126 ++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - signal bundle for the data memory, with a passive monitor view
interface data_mem_intf #(
    parameter int ADDR_W = 32
) (
    input logic clk
);
    logic [3:0]        wr_sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;

    modport monitor (
        input clk,
        input wr_sel,
        input addr,
        input wr_data,
        input rd_data
    );
endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory: async read, byte-masked sync write, async clear
module data_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [IDX_W-1:0] idx;

    // Byte offset and bits above the index are dropped, so addresses alias modulo DEPTH*4.
    assign idx = addr[IDX_W+1:2];

    logic unused_addr;
    assign unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

    assign rd_data = mem[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed vector table plus reset corners and random regression for data_mem
module tb_data_mem;
    logic        clk;
    logic        rst;
    logic [3:0]  wr_sel;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    int total;
    int bad;

    data_mem #(.DEPTH(256), .ADDR_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_sel  (wr_sel),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_before;
        logic [31:0] exp_after;
    } vec_t;

    vec_t vecs [11];
    logic [31:0] model [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        wr_sel = 4'h0;
        addr = '0;
        wr_data = '0;

        vecs[0]  = '{4'hF, 32'h010, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
        vecs[1]  = '{4'h0, 32'h010, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{4'h2, 32'h010, 32'h0000AA00, 32'hDEADBEEF, 32'hDEADAAEF};
        vecs[3]  = '{4'hC, 32'h010, 32'h12340000, 32'hDEADAAEF, 32'h1234AAEF};
        vecs[4]  = '{4'hF, 32'h021, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D};
        vecs[5]  = '{4'h0, 32'h020, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[6]  = '{4'h0, 32'h420, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[7]  = '{4'h0, 32'h020, 32'hFFFFFFFF, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[8]  = '{4'h1, 32'h422, 32'h000000AA, 32'hCAFEF00D, 32'hCAFEF0AA};
        vecs[9]  = '{4'h4, 32'h3FC, 32'h00550000, 32'h00000000, 32'h00550000};
        vecs[10] = '{4'h0, 32'h000, 32'h00000000, 32'h00000000, 32'h00000000};

        // Reset clear
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        addr = 32'h000; #1 check("reset_000", rd_data, 32'h0);
        addr = 32'h004; #1 check("reset_004", rd_data, 32'h0);
        addr = 32'h3FC; #1 check("reset_3fc", rd_data, 32'h0);

        // Vector table: compare before and after the capturing edge
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            wr_sel = vecs[i].sel;
            addr = vecs[i].a;
            wr_data = vecs[i].d;
            #1 check($sformatf("vec%0d_before", i), rd_data, vecs[i].exp_before);
            @(posedge clk);
            #1 check($sformatf("vec%0d_after", i), rd_data, vecs[i].exp_after);
            wr_sel = 4'h0;
        end

        // Async reset mid-cycle clears reads at once and blocks the pending write
        @(negedge clk);
        addr = 32'h010;
        #1 check("pre_rst_010", rd_data, 32'h1234AAEF);
        wr_sel = 4'hF;
        wr_data = 32'h55AA55AA;
        rst = 1'b1;
        #1 check("rst_async_010", rd_data, 32'h0);
        @(posedge clk);
        #1 check("rst_write_blocked", rd_data, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("first_edge_after_rst", rd_data, 32'h55AA55AA);
        wr_sel = 4'h0;

        // Random regression against a byte-masked model
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int w = 0; w < 256; w++) model[w] = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 500) begin
                wr_sel = 4'h0;
                rst = 1'b1;
                #1 check("rand_rst_read", rd_data, 32'h0);
                @(posedge clk);
                #1 rst = 1'b0;
                for (int w = 0; w < 256; w++) model[w] = '0;
                @(negedge clk);
            end
            wr_sel = 4'($urandom_range(0, 15));
            addr = 32'($urandom_range(0, 4095));
            wr_data = $urandom;
            #1 check($sformatf("rand%0d", i), rd_data, model[addr[9:2]]);
            @(posedge clk);
            for (int b = 0; b < 4; b++) begin
                if (wr_sel[b]) model[addr[9:2]][8*b +: 8] = wr_data[8*b +: 8];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
